// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and key lookup for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CANDIDATE,
    PRESSED,
    RELEASING
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_e;

  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] KEY_STAR  = 4'hE;
  localparam logic [3:0] KEY_HASH  = 4'hF;

  // Row r / column c of the physical keypad to the display nibble space.
  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 4-bit two-flop synchroniser, resets to all-ones (idle rows)
module sync_2ff (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad column scanner with debounce and one pulse per press
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned       SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [7:0]        DB        = 8'(DEBOUNCE_SCANS);

  logic [3:0]        row_sync;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [1:0]        acc_hits_q, acc_hits_d;
  logic [3:0]        acc_code_q, acc_code_d;
  state_e            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [7:0]        count_q, count_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

  logic [1:0] col_hits;
  logic [3:0] col_code;
  logic [2:0] hit_sum;
  logic [1:0] tot_hits;
  logic [3:0] tot_code;
  scan_e      scan_res;
  logic       sample;
  logic       scan_end;
  logic [7:0] col_rot;

  sync_2ff u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (row),
    .q_o (row_sync)
  );

  assign col_rot = {COL_RESET, COL_RESET} << col_idx_q;
  assign col     = col_rot[7:4];

  assign sample   = (slot_q == SLOT_LAST);
  assign scan_end = sample && (col_idx_q == 2'd3);

  // Hit count saturates at 2: anything beyond one pressed pair is MULTI.
  always_comb begin
    col_hits = 2'd0;
    col_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_code = key_lookup(2'(r), col_idx_q);
      end
    end
    hit_sum  = {1'b0, acc_hits_q} + {1'b0, col_hits};
    tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    tot_code = (col_hits != 2'd0) ? col_code : acc_code_q;
    case (tot_hits)
      2'd0:    scan_res = NONE;
      2'd1:    scan_res = SINGLE;
      default: scan_res = MULTI;
    endcase
  end

  always_comb begin
    slot_d     = slot_q + SLOT_W'(1);
    col_idx_d  = col_idx_q;
    acc_hits_d = acc_hits_q;
    acc_code_d = acc_code_q;
    if (sample) begin
      slot_d     = '0;
      col_idx_d  = col_idx_q + 2'd1;
      acc_hits_d = scan_end ? 2'd0 : tot_hits;
      acc_code_d = scan_end ? 4'h0 : tot_code;
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    count_d     = count_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (scan_res == SINGLE) begin
            if (DB <= 8'd1) begin
              state_d     = PRESSED;
              key_code_d  = tot_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = CANDIDATE;
              cand_d  = tot_code;
              count_d = 8'd1;
            end
          end
        end
        CANDIDATE: begin
          if (scan_res == SINGLE && tot_code == cand_q) begin
            if (count_q + 8'd1 >= DB) begin
              state_d     = PRESSED;
              count_d     = 8'd0;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              count_d = count_q + 8'd1;
            end
          end else if (scan_res == SINGLE) begin
            cand_d  = tot_code;
            count_d = 8'd1;
          end else begin
            state_d = IDLE;
            count_d = 8'd0;
          end
        end
        PRESSED: begin
          if (scan_res == NONE) begin
            if (DB <= 8'd1) begin
              state_d    = IDLE;
              count_d    = 8'd0;
              key_held_d = 1'b0;
            end else begin
              state_d = RELEASING;
              count_d = 8'd1;
            end
          end
        end
        RELEASING: begin
          if (scan_res != NONE) begin
            // Release bounce: the key is still the same press, so no new pulse.
            state_d = PRESSED;
            count_d = 8'd0;
          end else if (count_q + 8'd1 >= DB) begin
            state_d    = IDLE;
            count_d    = 8'd0;
            key_held_d = 1'b0;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= '0;
      col_idx_q   <= 2'd0;
      acc_hits_q  <= 2'd0;
      acc_code_q  <= 4'h0;
      state_q     <= IDLE;
      cand_q      <= 4'h0;
      count_q     <= 8'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      col_idx_q   <= col_idx_d;
      acc_hits_q  <= acc_hits_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      count_q     <= count_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
